// File: rtl/clmul_unit.sv
`default_nettype none
// ============================================================================
// Module      : clmul_unit
// Description : Multi-cycle carry-less multiply unit (CLMUL / CLMULH).
//               Consumes BITS_PER_CYCLE multiplier bits per RUN cycle, stalls
//               the front end while iterating, then emits a one-cycle done
//               pulse with the product word and the latched destination reg.
//               Optional macro CLMULR_EN adds op 10 = CLMULR (acc[62:31]).
// Revision    : 1.0 - initial release
// ============================================================================
module clmul_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      delayed_rd
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    // A single-iteration configuration still needs a 1-bit counter.
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(ITERS - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2*XLEN-1:0] r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_delayed_rd;

    logic              w_accept;
    logic              w_last;
    logic [2*XLEN-1:0] w_partial;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0]   w_res_sel;

    assign w_accept  = (r_state == c_idle) && start && !kill;
    assign w_last    = (r_state == c_run) && (r_cnt == c_last_cnt);
    assign w_acc_nxt = r_acc ^ w_partial;

    // State register; reset overrides everything, including mid-RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the handshake outputs (stall is combinational so
    // the issuing instruction is held in its own accept cycle).
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        busy        = (r_state != c_idle);
        done        = 1'b0;
        case (r_state)
            c_idle: begin
                if (start && !kill) begin
                    w_state_nxt = c_run;
                    stall       = 1'b1;
                end
            end
            c_run: begin
                stall = 1'b1;
                if (kill) begin
                    w_state_nxt = c_idle;
                end else if (r_cnt == c_last_cnt) begin
                    w_state_nxt = c_done;
                end
            end
            c_done: begin
                done        = !kill;
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // XOR of the shifted multiplicand for every set multiplier bit this cycle.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_b[j]) begin
                w_partial = w_partial ^ (r_a << j);
            end
        end
    end

    // Word select from the final accumulator; reserved encodings fall to low.
    always_comb begin
        w_res_sel = w_acc_nxt[XLEN-1:0];
        if (r_op == 2'b01) begin
            w_res_sel = w_acc_nxt[2*XLEN-1:XLEN];
        end
`ifdef CLMULR_EN
        else if (r_op == 2'b10) begin
            w_res_sel = w_acc_nxt[2*XLEN-2:XLEN-1];
        end
`endif
    end

    // Operand latch, iteration datapath, and result capture on the final
    // RUN edge so result/delayed_rd are already stable during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_op         <= '0;
            r_rd         <= '0;
            r_result     <= '0;
            r_delayed_rd <= '0;
        end else if (w_accept) begin
            r_a   <= {{XLEN{1'b0}}, rs1_val};
            r_b   <= rs2_val;
            r_op  <= op;
            r_rd  <= rd_in;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == c_run) begin
            r_acc <= w_acc_nxt;
            r_a   <= r_a << BITS_PER_CYCLE;
            r_b   <= r_b >> BITS_PER_CYCLE;
            r_cnt <= r_cnt + 1'b1;
            if (w_last && !kill) begin
                r_result     <= w_res_sel;
                r_delayed_rd <= r_rd;
            end
        end
    end

    assign result     = r_result;
    assign delayed_rd = r_delayed_rd;

endmodule
`default_nettype wire

// File: tb/tb_clmul_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_clmul_unit
// Description : Scoreboard bench for clmul_unit. The driver pushes expected
//               {result, rd, done cycle} per accepted op; a negedge monitor
//               pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clmul_unit;

    localparam int BPC   = 4;
    localparam int ITERS = 32 / BPC;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in   = '0;
    logic        kill    = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  delayed_rd;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    clmul_unit #(.XLEN(32), .BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd_in      (rd_in),
        .kill       (kill),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .delayed_rd (delayed_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: carry-less product as the XOR of shifted copies of x.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) p = p ^ (64'(x) << i);
        end
        if (o == 2'b01) return p[63:32];
`ifdef CLMULR_EN
        if (o == 2'b10) return p[62:31];
`endif
        return p[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse result 0x%08h at cycle %0d expected none",
                         result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("delayed_rd", {27'b0, delayed_rd}, {27'b0, mon_e.rd});
                chk("done_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic [4:0] d, input int due);
        exp_t e;
        e.res = r;
        e.rd  = d;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d outstanding ops expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    // Issue one op; operand inputs are scrambled after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r, input logic [31:0] expv, input bit chk_stall);
        start   = 1'b1;
        op      = o;
        rs1_val = x;
        rs2_val = y;
        rd_in   = r;
        push_exp(expv, r, cyc + ITERS + 1);
        if (chk_stall) begin
            for (int k = 0; k <= ITERS + 1; k++) begin
                #2;
                chk($sformatf("stall_c%0d", k), {31'b0, stall}, 32'(k <= ITERS));
                tick();
                start   = 1'b0;
                rs1_val = $urandom;
                rs2_val = $urandom;
            end
        end else begin
            tick();
            start   = 1'b0;
            op      = 2'($urandom_range(0, 3));
            rs1_val = $urandom;
            rs2_val = $urandom;
            rd_in   = 5'($urandom);
        end
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp_r;
        int          c0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'b0, delayed_rd}, 32'd0);
        tick();

        // Directed products, with stall profile on the first
        run_op(2'b00, 32'h00000003, 32'h00000003, 5'd7, 32'h00000005, 1'b1);
        run_op(2'b01, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 5'd10, 32'h00000000, 1'b0);
`ifdef CLMULR_EN
        exp_r = 32'h80000000;
`else
        exp_r = 32'h00000000;
`endif
        run_op(2'b10, 32'h80000000, 32'h80000000, 5'd11, exp_r, 1'b0);
        run_op(2'b11, 32'h00000003, 32'h00000003, 5'd12, 32'h00000005, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h55555555, 1'b0);

        // Back-to-back: start held high through RUN and DONE
        c0      = cyc;
        start   = 1'b1;
        op      = 2'b00;
        rs1_val = 32'h0000000F;
        rs2_val = 32'h00000005;
        rd_in   = 5'd3;
        push_exp(32'h00000033, 5'd3, c0 + ITERS + 1);
        tick();
        op      = 2'b01;
        rs1_val = 32'hF0000000;
        rs2_val = 32'h00000011;
        rd_in   = 5'd4;
        push_exp(32'h0000000F, 5'd4, c0 + ITERS + 2 + ITERS + 1);
        repeat (ITERS + 1) tick();
        tick();
        start = 1'b0;
        wait_drain();

        // Reset in RUN cycle 3
        start   = 1'b1;
        op      = 2'b00;
        rs1_val = 32'h12345678;
        rs2_val = 32'h9ABCDEF1;
        rd_in   = 5'd21;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        repeat (ITERS + 4) tick();

        // start with kill in IDLE is ignored
        start = 1'b1;
        kill  = 1'b1;
        #2;
        chk("idle_kill_stall", {31'b0, stall}, 32'd0);
        tick();
        start = 1'b0;
        kill  = 1'b0;
        #2;
        chk("idle_kill_busy", {31'b0, busy}, 32'd0);
        tick();

        // Kill in RUN cycle 5
        start   = 1'b1;
        rs1_val = 32'hDEADBEEF;
        rs2_val = 32'h0000FFFF;
        rd_in   = 5'd22;
        tick();
        start = 1'b0;
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #2;
        chk("run_kill_busy", {31'b0, busy}, 32'd0);
        repeat (ITERS + 4) tick();

        // Kill in the DONE cycle
        start   = 1'b1;
        rs1_val = 32'h0F0F0F0F;
        rs2_val = 32'h00000101;
        rd_in   = 5'd23;
        tick();
        start = 1'b0;
        repeat (ITERS) tick();
        kill = 1'b1;
        #2;
        chk("done_kill_busy", {31'b0, busy}, 32'd1);
        chk("done_kill_done", {31'b0, done}, 32'd0);
        tick();
        kill = 1'b0;
        #2;
        chk("done_kill_idle", {31'b0, busy}, 32'd0);
        tick();

        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd24, 32'hFFFFFFFE, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = (i % 6 == 0) ? 32'h0 : $urandom;
            y = (i % 6 == 3) ? 32'h0 : $urandom;
            run_op(o, x, y, 5'($urandom), model(o, x, y), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clmul_unit.md
Name: clmul_unit

Overview:
- Multi-cycle carry-less multiply execution unit for the Zbc/Zbkc bitmanip subset.
- Executes the CLMUL/CLMULH operations flagged by the instruction decoder.
- Holds the pipeline with a stall while it iterates, then returns one result pulse plus the destination register for the delayed write-back path.
- Sits beside the ALU; the core writes back its `done`/`result`/`delayed_rd` the same way it handles a delayed load.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- BITS_PER_CYCLE, 4, multiplier bits consumed per RUN cycle; legal values 1, 2, 4, 8, 16, 32.
- ITERS, XLEN/BITS_PER_CYCLE, derived; number of RUN cycles; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  decoder flags clmul/clmulh this cycle; qualified with is_bitmanip upstream
- op  in  2  00=clmul, 01=clmulh, 10=clmulr (only with CLMULR_EN), 11 reserved
- rs1_val  in  32  multiplicand
- rs2_val  in  32  multiplier
- rd_in  in  5  destination register of the issuing instruction
- kill  in  1  flush; aborts the operation in flight
- stall  out  1  holds PC/fetch while the op is accepted or running
- busy  out  1  state != IDLE
- done  out  1  single-cycle result-valid pulse; this is the core's delayed_clmul
- result  out  32  product word; valid only when done=1
- delayed_rd  out  5  latched rd; valid when done=1

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at an edge) forces IDLE, clears acc/cnt/result/delayed_rd/op_q to 0. Outputs after reset: stall=0, busy=0, done=0, result=0, delayed_rd=0. Reset wins over every other input, including mid-RUN.
- IDLE, start=1, kill=0:
  - latch a=rs1_val zero-extended to 64 bits, b=rs2_val, op_q=op, rd_q=rd_in;
  - clear acc (64b) and cnt;
  - go to RUN.
- IDLE, start=1, kill=1: ignored; stay in IDLE.
- RUN, per cycle:
  - for j in 0..BITS_PER_CYCLE-1: if b[j], acc ^= a << j;
  - then a <<= BITS_PER_CYCLE, b >>= BITS_PER_CYCLE, cnt++;
  - when cnt reaches ITERS-1 on that edge, go to DONE.
- DONE, one cycle:
  - done=1, delayed_rd=rd_q;
  - result = acc[31:0] for op 00, acc[63:32] for op 01;
  - next state IDLE.
- Latency: start sampled at edge T → RUN occupies cycles T+1..T+ITERS → done=1 in cycle T+ITERS+1 (9 cycles after start for BITS_PER_CYCLE=4).
- stall = (IDLE & start & !kill) | RUN. It is combinational, so the issuing instruction is held in the same cycle it is accepted. stall=0 in DONE so the core advances while writing back.
- Back-to-back: start during RUN is ignored, since the held instruction cannot re-issue. start during DONE is ignored; the next op is accepted from IDLE one cycle later.
- kill during RUN or DONE: next state IDLE, done forced 0 that cycle, and no write-back occurs.
- result and delayed_rd hold their last value outside DONE; consumers qualify them with done.
- Reserved op (11), and op 10 without the macro: computed as clmul (low word).
- Zero operands still take the full ITERS cycles; there is no early termination.

Optional Feature:
- Macro CLMULR_EN.
- Defined: op 10 returns clmulr = acc[62:31], i.e. bit-reversed clmul of bit-reversed operands.
- Undefined: op 10 is treated as op 00. No extra mux logic is synthesized.

Test Plan:
- clmul, rs1=0x00000003, rs2=0x00000003, BITS_PER_CYCLE=4 → done exactly 9 cycles after start, result=0x00000005, stall high for cycles 0..8, delayed_rd=rd_in.
- clmulh, rs1=0x80000000, rs2=0x80000000 → result=0x40000000. Same operands with clmul → result=0x00000000.
- CLMULR_EN defined, op=10, rs1=rs2=0x80000000 → result=0x80000000. Macro undefined, same stimulus → result=0x00000000.
- start pulsed again every cycle during RUN and DONE → exactly one done pulse per accepted op; the second op is accepted only from IDLE, and its done arrives 9 cycles after that acceptance.
- rst=1 at RUN cycle 3 → next cycle busy=0, stall=0, done=0, result=0; no done pulse ever appears for the aborted op.
- kill=1 at RUN cycle 5 → IDLE next cycle, no done. Repeat with kill in the DONE cycle → done=0 that cycle. A fresh start afterwards, rs1=0xFFFFFFFF, rs2=0x00000002, clmul → result=0xFFFFFFFE.
